// File: rtl/load_store_unit.sv
// Load/store unit: latches one memory op from execute, runs the data-bus handshake,
// and returns extended load data. Build with LSU_TIMEOUT_EN for the handshake watchdog.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            i_Clock,
  input  logic            i_Reset_N,
  input  logic            i_Start,
  input  logic [4:0]      i_Load_Store_Type,
  input  logic [XLEN-1:0] i_Addr,
  input  logic [XLEN-1:0] i_Store_Data,
  output logic            o_Busy,
  output logic            o_Done,
  output logic [XLEN-1:0] o_Load_Data,
  output logic            o_Misaligned,
  output logic            o_Bus_Error,
  output logic            o_Mem_Req,
  output logic            o_Mem_Write,
  output logic [XLEN-1:0] o_Mem_Addr,
  output logic [XLEN-1:0] o_Mem_Wdata,
  output logic [3:0]      o_Mem_Byte_En,
  input  logic            i_Mem_Ready,
  input  logic            i_Mem_Rvalid,
  input  logic [XLEN-1:0] i_Mem_Rdata
);

  // state     | meaning
  // IDLE      | waiting for i_Start with a valid type
  // REQ       | request on the bus until i_Mem_Ready
  // WAIT_RESP | load accepted, waiting for i_Mem_Rvalid
  // DONE      | one-cycle completion with status flags
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, DONE} state_t;

  localparam logic [4:0] T_LB = 5'd1, T_LH = 5'd2, T_LW = 5'd3, T_LBU = 5'd4,
                         T_LHU = 5'd5, T_SB = 5'd6, T_SH = 5'd7, T_SW = 5'd8;

  if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("load_store_unit: XLEN must be 32 and TIMEOUT_CYCLES at least 1");
  end

  state_t          state, state_next;
  logic [4:0]      typ_q;
  logic [XLEN-1:0] addr_q, data_q, load_data_q;
  logic            misaligned_q, bus_err_q;
  logic            accept, mis_in, is_store_q, timeout;
  logic [3:0]      be_int;
  logic [XLEN-1:0] wdata_int, load_ext;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;

  always_comb begin
    accept = 1'b0;
    mis_in = 1'b0;
    if (state == IDLE && i_Start && i_Load_Store_Type >= T_LB && i_Load_Store_Type <= T_SW)
      accept = 1'b1;
    if (i_Load_Store_Type == T_LH || i_Load_Store_Type == T_LHU || i_Load_Store_Type == T_SH)
      mis_in = i_Addr[0];
    else if (i_Load_Store_Type == T_LW || i_Load_Store_Type == T_SW)
      mis_in = |i_Addr[1:0];
    is_store_q = (typ_q == T_SB) || (typ_q == T_SH) || (typ_q == T_SW);
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Counter holds the number of cycles already spent in the current wait state.
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N)
      tmo_cnt <= '0;
    else if (state_next != state)
      tmo_cnt <= '0;
    else if (state == REQ || state == WAIT_RESP)
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == REQ || state == WAIT_RESP) && (tmo_cnt == TMO_LAST);
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = mis_in ? DONE : REQ;
      REQ: begin
        if (i_Mem_Ready)  state_next = is_store_q ? DONE : WAIT_RESP;
        else if (timeout) state_next = DONE;
      end
      WAIT_RESP: if (i_Mem_Rvalid || timeout) state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state        <= IDLE;
      typ_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      load_data_q  <= '0;
      misaligned_q <= 1'b0;
      bus_err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        typ_q        <= i_Load_Store_Type;
        addr_q       <= i_Addr;
        data_q       <= i_Store_Data;
        misaligned_q <= mis_in;
        bus_err_q    <= 1'b0;
      end
      if (state == WAIT_RESP && i_Mem_Rvalid)
        load_data_q <= load_ext;
      else if ((state == REQ && !i_Mem_Ready && timeout) ||
               (state == WAIT_RESP && timeout))
        bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    be_int    = 4'b0000;
    wdata_int = '0;
    case (typ_q)
      T_SB: begin
        be_int    = 4'b0001 << addr_q[1:0];
        wdata_int = {4{data_q[7:0]}};
      end
      T_SH: begin
        be_int    = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_int = {2{data_q[15:0]}};
      end
      T_SW: begin
        be_int    = 4'b1111;
        wdata_int = data_q;
      end
      default: be_int = 4'b1111;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    rbyte = i_Mem_Rdata[7:0];
      2'd1:    rbyte = i_Mem_Rdata[15:8];
      2'd2:    rbyte = i_Mem_Rdata[23:16];
      default: rbyte = i_Mem_Rdata[31:24];
    endcase
    rhalf = addr_q[1] ? i_Mem_Rdata[31:16] : i_Mem_Rdata[15:0];
    case (typ_q)
      T_LB:    load_ext = {{(XLEN-8){rbyte[7]}}, rbyte};
      T_LBU:   load_ext = {{(XLEN-8){1'b0}}, rbyte};
      T_LH:    load_ext = {{(XLEN-16){rhalf[15]}}, rhalf};
      T_LHU:   load_ext = {{(XLEN-16){1'b0}}, rhalf};
      default: load_ext = i_Mem_Rdata;
    endcase
  end

  // Bus fields are forced to zero outside REQ so nothing leaks while idle or in reset.
  assign o_Mem_Req     = (state == REQ);
  assign o_Mem_Write   = o_Mem_Req && is_store_q;
  assign o_Mem_Addr    = o_Mem_Req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign o_Mem_Wdata   = o_Mem_Req ? wdata_int : '0;
  assign o_Mem_Byte_En = o_Mem_Req ? be_int : 4'b0000;
  assign o_Busy        = (state != IDLE);
  assign o_Done        = (state == DONE);
  assign o_Misaligned  = o_Done && misaligned_q;
  assign o_Bus_Error   = o_Done && bus_err_q;
  assign o_Load_Data   = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a bus responder plus a scoreboard of expected
// completion results popped on each o_Done.
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset_N;
  logic        i_Start;
  logic [4:0]  i_Load_Store_Type;
  logic [31:0] i_Addr, i_Store_Data;
  logic        o_Busy, o_Done, o_Misaligned, o_Bus_Error;
  logic [31:0] o_Load_Data;
  logic        o_Mem_Req, o_Mem_Write;
  logic [31:0] o_Mem_Addr, o_Mem_Wdata;
  logic [3:0]  o_Mem_Byte_En;
  logic        i_Mem_Ready, i_Mem_Rvalid;
  logic [31:0] i_Mem_Rdata;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TMO)) dut (
    .i_Clock(i_Clock), .i_Reset_N(i_Reset_N), .i_Start(i_Start),
    .i_Load_Store_Type(i_Load_Store_Type), .i_Addr(i_Addr), .i_Store_Data(i_Store_Data),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Load_Data(o_Load_Data),
    .o_Misaligned(o_Misaligned), .o_Bus_Error(o_Bus_Error),
    .o_Mem_Req(o_Mem_Req), .o_Mem_Write(o_Mem_Write), .o_Mem_Addr(o_Mem_Addr),
    .o_Mem_Wdata(o_Mem_Wdata), .o_Mem_Byte_En(o_Mem_Byte_En),
    .i_Mem_Ready(i_Mem_Ready), .i_Mem_Rvalid(i_Mem_Rvalid), .i_Mem_Rdata(i_Mem_Rdata)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [31:0] load_data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_load = '0;

  int          ready_delay = 0;
  bit          ready_en = 1'b1;
  logic [31:0] rdata_word = '0;
  int          req_cycles = 0;
  int          req_accepts = 0;
  logic        acc_load;
  logic [31:0] first_addr, first_wdata;
  logic [3:0]  first_be;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  // Bus model: ready after ready_delay request cycles, rvalid the cycle after a load is accepted.
  always begin
    @(posedge i_Clock);
    acc_load = o_Mem_Req && i_Mem_Ready && !o_Mem_Write && i_Reset_N;
    if (o_Mem_Req && i_Mem_Ready && i_Reset_N) req_accepts++;
    #1;
    i_Mem_Rvalid = acc_load;
    i_Mem_Rdata  = acc_load ? rdata_word : 32'h0;
    if (o_Mem_Req) begin
      req_cycles++;
      if (req_cycles == 1) begin
        first_addr  = o_Mem_Addr;
        first_wdata = o_Mem_Wdata;
        first_be    = o_Mem_Byte_En;
      end else begin
        chk("req_addr_stable", o_Mem_Addr, first_addr);
        chk("req_wdata_stable", o_Mem_Wdata, first_wdata);
        chk("req_be_stable", {28'h0, o_Mem_Byte_En}, {28'h0, first_be});
      end
    end else begin
      req_cycles = 0;
    end
    i_Mem_Ready = o_Mem_Req && ready_en && (req_cycles > ready_delay);
  end

  function automatic logic [31:0] model_load(input logic [4:0] t, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0]        sh;
    logic signed [7:0]  sb8;
    logic signed [15:0] sh16;
    sh   = rd >> (8 * a[1:0]);
    sb8  = sh[7:0];
    sh16 = sh[15:0];
    case (t)
      5'd1:    return 32'(sb8);
      5'd4:    return {24'h0, sh[7:0]};
      5'd2:    return 32'(sh16);
      5'd5:    return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  task automatic issue(input logic [4:0] t, input logic [31:0] a, input logic [31:0] d,
                       input bit exp_tmo);
    exp_t e;
    bit   mis;
    mis = ((t == 5'd2 || t == 5'd5 || t == 5'd7) && a[0]) ||
          ((t == 5'd3 || t == 5'd8) && (a[1:0] != 2'b00));
    if (!mis && !exp_tmo && t >= 5'd1 && t <= 5'd5)
      last_load = model_load(t, a, rdata_word);
    e.load_data = last_load;
    e.mis       = mis;
    e.berr      = exp_tmo && !mis;
    sb.push_back(e);
    i_Load_Store_Type = t;
    i_Addr            = a;
    i_Store_Data      = d;
    i_Start           = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic run_to_done(input string tag, input int start_cyc, input int exp_cyc);
    int   cyc;
    exp_t e;
    cyc = start_cyc;
    while (o_Done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_done"}, {31'h0, o_Done}, 32'h1);
    chk({tag, "_latency"}, cyc, exp_cyc);
    chk({tag, "_busy_in_done"}, {31'h0, o_Busy}, 32'h1);
    chk({tag, "_req_in_done"}, {31'h0, o_Mem_Req}, 32'h0);
    chk({tag, "_sb_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_load_data"}, o_Load_Data, e.load_data);
      chk({tag, "_misaligned"}, {31'h0, o_Misaligned}, {31'h0, e.mis});
      chk({tag, "_bus_error"}, {31'h0, o_Bus_Error}, {31'h0, e.berr});
    end
    tick();
    chk({tag, "_done_one_cycle"}, {31'h0, o_Done}, 32'h0);
    chk({tag, "_idle_after"}, {31'h0, o_Busy}, 32'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, o_Busy}, 32'h0);
    chk({tag, "_done"}, {31'h0, o_Done}, 32'h0);
    chk({tag, "_load_data"}, o_Load_Data, 32'h0);
    chk({tag, "_mis"}, {31'h0, o_Misaligned}, 32'h0);
    chk({tag, "_berr"}, {31'h0, o_Bus_Error}, 32'h0);
    chk({tag, "_req"}, {31'h0, o_Mem_Req}, 32'h0);
    chk({tag, "_write"}, {31'h0, o_Mem_Write}, 32'h0);
    chk({tag, "_addr"}, o_Mem_Addr, 32'h0);
    chk({tag, "_wdata"}, o_Mem_Wdata, 32'h0);
    chk({tag, "_be"}, {28'h0, o_Mem_Byte_En}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int acc0;
    i_Reset_N = 1'b0; i_Start = 1'b0; i_Load_Store_Type = '0; i_Addr = '0; i_Store_Data = '0;
    i_Mem_Ready = 1'b0; i_Mem_Rvalid = 1'b0; i_Mem_Rdata = '0;
    repeat (3) tick();
    check_all_zero("reset");
    i_Reset_N = 1'b1;
    tick();

    // SB to byte lane 3, with a start pulse while busy that must be ignored
    acc0 = req_accepts;
    issue(5'd6, 32'h1003, 32'h000000AB, 1'b0);
    chk("sb_busy_t1", {31'h0, o_Busy}, 32'h1);
    chk("sb_req_t1", {31'h0, o_Mem_Req}, 32'h1);
    chk("sb_write", {31'h0, o_Mem_Write}, 32'h1);
    chk("sb_addr", o_Mem_Addr, 32'h1000);
    chk("sb_be", {28'h0, o_Mem_Byte_En}, 32'h8);
    chk("sb_wdata", o_Mem_Wdata, 32'hABABABAB);
    i_Load_Store_Type = 5'd3; i_Addr = 32'h0; i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    run_to_done("sb", 2, 2);
    chk("busy_start_ignored", req_accepts - acc0, 1);

    // Byte loads with sign and zero extension
    rdata_word = 32'h1234F0AA;
    issue(5'd1, 32'h2001, 32'h0, 1'b0);
    run_to_done("lb", 1, 3);
    issue(5'd4, 32'h2001, 32'h0, 1'b0);
    run_to_done("lbu", 1, 3);

    // Halfword loads; first one with ready held off for three cycles
    rdata_word = 32'h8001FFFF;
    ready_delay = 3;
    issue(5'd2, 32'h2002, 32'h0, 1'b0);
    chk("lh_addr", o_Mem_Addr, 32'h2000);
    chk("lh_write", {31'h0, o_Mem_Write}, 32'h0);
    run_to_done("lh", 1, 6);
    ready_delay = 0;
    issue(5'd5, 32'h2002, 32'h0, 1'b0);
    run_to_done("lhu", 1, 3);

    // Misaligned word and half: immediate completion, no bus request
    acc0 = req_accepts;
    issue(5'd3, 32'h3002, 32'h0, 1'b0);
    chk("lw_mis_no_req", {31'h0, o_Mem_Req}, 32'h0);
    run_to_done("lw_mis", 1, 1);
    issue(5'd7, 32'h0005, 32'h5555, 1'b0);
    run_to_done("sh_mis", 1, 1);
    chk("mis_no_bus", req_accepts - acc0, 0);

    // Invalid types are ignored
    i_Load_Store_Type = 5'd0; i_Start = 1'b1;
    tick();
    chk("type0_ignored", {31'h0, o_Busy}, 32'h0);
    i_Load_Store_Type = 5'd9;
    tick();
    i_Start = 1'b0;
    chk("type9_ignored", {31'h0, o_Busy}, 32'h0);

    // Word load, then a halfword store back to back
    rdata_word = 32'hCAFEF00D;
    issue(5'd3, 32'h3000, 32'h0, 1'b0);
    run_to_done("lw", 1, 3);
    issue(5'd7, 32'h0002, 32'h1234ABCD, 1'b0);
    chk("sh_be", {28'h0, o_Mem_Byte_En}, 32'hC);
    chk("sh_wdata", o_Mem_Wdata, 32'hABCDABCD);
    chk("sh_addr", o_Mem_Addr, 32'h0);
    run_to_done("sh", 1, 2);

    // Reset while waiting for load data
    rdata_word = 32'h11112222;
    issue(5'd3, 32'h3000, 32'h0, 1'b0);
    tick();
    chk("rst_pre_busy", {31'h0, o_Busy}, 32'h1);
    chk("rst_pre_req", {31'h0, o_Mem_Req}, 32'h0);
    #2 i_Reset_N = 1'b0;
    #1;
    check_all_zero("midrst");
    sb.delete();
    last_load = '0;
    tick();
    tick();
    i_Reset_N = 1'b1;
    tick();
    issue(5'd8, 32'h0040, 32'hDEADBEEF, 1'b0);
    chk("sw_addr", o_Mem_Addr, 32'h40);
    chk("sw_be", {28'h0, o_Mem_Byte_En}, 32'hF);
    chk("sw_wdata", o_Mem_Wdata, 32'hDEADBEEF);
    chk("sw_write", {31'h0, o_Mem_Write}, 32'h1);
    run_to_done("sw", 1, 2);

`ifdef LSU_TIMEOUT_EN
    // Watchdog: ready never comes; a start during busy must not be taken
    rdata_word = 32'h0BADF00D;
    ready_en = 1'b0;
    acc0 = req_accepts;
    issue(5'd3, 32'h0100, 32'h0, 1'b1);
    i_Load_Store_Type = 5'd8; i_Addr = 32'h0; i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
    run_to_done("tmo", 2, 1 + TMO);
    ready_en = 1'b1;
    tick();
    chk("tmo_busy_start_ignored", {31'h0, o_Busy}, 32'h0);
    chk("tmo_no_accept", req_accepts - acc0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Executes the memory operations selected by the decoder's load/store type and performs the data-memory handshake.
- Latches address (ALU result), store data and type.
- Issues an aligned word request with byte enables, then returns the sign- or zero-extended load result.
- Sits between execute and the data-memory bus; o_Busy stalls the pipeline.

Parameters:
XLEN, 32, data/address width (only 32 supported)
TIMEOUT_CYCLES, 255, handshake watchdog limit (used only with LSU_TIMEOUT_EN)

Ports:
i_Clock  input  1  system clock
i_Reset_N  input  1  asynchronous, active-low reset
i_Start  input  1  request strobe from execute
i_Load_Store_Type  input  5  NONE=0, LB=1, LH=2, LW=3, LBU=4, LHU=5, SB=6, SH=7, SW=8
i_Addr  input  XLEN  byte address
i_Store_Data  input  XLEN  rs2 value
o_Busy  output  1  operation in flight; stall pipeline
o_Done  output  1  one-cycle completion pulse
o_Load_Data  output  XLEN  extended load result
o_Misaligned  output  1  valid with o_Done; access was misaligned
o_Bus_Error  output  1  valid with o_Done; watchdog expired (feature only)
o_Mem_Req  output  1  bus request valid
o_Mem_Write  output  1  1=store, 0=load
o_Mem_Addr  output  XLEN  word-aligned address {addr[31:2],2'b00}
o_Mem_Wdata  output  XLEN  lane-replicated store data
o_Mem_Byte_En  output  4  byte lane enables
i_Mem_Ready  input  1  bus accepts request this cycle
i_Mem_Rvalid  input  1  load data valid
i_Mem_Rdata  input  XLEN  load data word

Behaviour:
- Reset (async, any state): FSM to IDLE; every output 0, including o_Load_Data. o_Mem_Req drops immediately, even mid-handshake. No partial store completes.
- FSM states: IDLE, REQ, WAIT_RESP, DONE.
- IDLE:
  - Accepts a request when i_Start=1 and the type is 1..8. Type 0 or >8 is ignored.
  - On accept, latches type, addr and data.
  - Aligned access goes to REQ.
  - Misaligned access goes to DONE with o_Misaligned set and no bus activity. Misaligned means H with addr[0]=1, or W with addr[1:0]!=0.
- REQ:
  - o_Mem_Req=1; address, wdata, byte enables and write are stable until i_Mem_Ready=1.
  - On ready, a store goes to DONE and a load goes to WAIT_RESP.
  - i_Mem_Rvalid is ignored in REQ.
- WAIT_RESP: o_Mem_Req=0. On i_Mem_Rvalid, registers the extracted and extended data into o_Load_Data, then goes to DONE.
- DONE: o_Done=1 for one cycle, then IDLE. o_Misaligned and o_Bus_Error are meaningful only here and are 0 elsewhere.
- o_Busy = (state != IDLE). i_Start is ignored while busy.
- o_Load_Data holds its value until the next successful load. Stores and faults do not change it.
- Store lanes:
  - SB: Byte_En = 1<<addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: Byte_En = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - SW: Byte_En = 1111; wdata = data.
- Load lanes:
  - LB/LBU select byte addr[1:0].
  - LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- Latency, with ready and rvalid each asserted on first opportunity:
  - Store: Start at T0, REQ at T1, o_Done at T2.
  - Load: Start at T0, REQ at T1, WAIT_RESP at T2 (rvalid at T2), o_Done and data at T3.
  - Misaligned: o_Done at T1.
- Back-to-back: a new i_Start is accepted in the cycle after DONE (IDLE).

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - An 8-bit-min counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering REQ or WAIT_RESP and increments each cycle while in either state.
  - When it reaches TIMEOUT_CYCLES, the unit drops o_Mem_Req and goes to DONE with o_Bus_Error=1. o_Load_Data is unchanged.
- Undefined: no counter; the unit waits indefinitely; o_Bus_Error is tied 0.

Test Plan:
1. SB, addr=0x1003, data=0xAB, ready at T1 -> o_Mem_Addr=0x1000, Byte_En=1000, Wdata=0xABABABAB, o_Done at T2, o_Busy T1-T2.
2. LB, addr=0x2001, Rdata=0x00008000... use Rdata=0x1234F0AA -> LB returns 0xFFFFFFF0; LBU at the same address returns 0x000000F0; o_Done 1 cycle after rvalid.
3. LH, addr=0x2002, Rdata=0x8001FFFF -> 0xFFFF8001; LHU -> 0x00008001; ready held low 3 cycles -> Req/Addr stable, o_Done delayed 3 cycles.
4. LW, addr=0x3002 -> o_Done at T1 with o_Misaligned=1, o_Mem_Req never asserted, o_Load_Data unchanged.
5. LW issued, i_Reset_N pulled low while in WAIT_RESP -> all outputs 0 immediately; after release, an SW at 0x40 with data 0xDEADBEEF completes normally with Byte_En=1111.
6. LSU_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, ready never asserted -> o_Done with o_Bus_Error=1 exactly 4 cycles after REQ entry, then IDLE; i_Start during busy ignored.
